data_mux: RTL and testbench

Parameterised, registered N-to-1 word multiplexer: selects one of 2**SELECT_LINES packed DATA_WIDTH-bit input words by a binary select and presents it on a registered output. It is a generic datapath primitive used wherever a runtime-selectable lane or channel must be picked from a packed bus. A behavioural or structural (2:1 tree) implementation is chosen by parameter; both must be cycle-identical.

---
 rtl/mux_pkg.sv | 18 +
 rtl/mux2.sv | 14 +
 rtl/data_mux.sv | 97 +++++++++
 tb/tb_data_mux.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Shared constants for the data_mux word multiplexer.
// MUX_INPUT_REG_EN adds an input register stage (latency 2).
package mux_pkg;

  localparam string ARCH_BEHAVIORAL = "BEHAVIORAL";
  localparam string ARCH_STRUCTURAL = "STRUCTURAL";

  function automatic int unsigned mux_latency();
`ifdef MUX_INPUT_REG_EN
    return 2;
`else
    return 1;
`endif
  endfunction

  localparam int unsigned LATENCY = mux_latency();

endpackage

// File: rtl/mux2.sv
// DATA_WIDTH-wide 2:1 combinational mux, leaf of the tree.
// sel=0 passes a, sel=1 passes b.
module mux2 #(
  parameter int DATA_WIDTH = 1
) (
  input  logic                  sel,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] y
);

  assign y = sel ? b : a;

endmodule

// File: rtl/data_mux.sv
// Registered N-to-1 word mux, behavioural or 2:1 tree.
// MUX_INPUT_REG_EN registers select/data/valid first.
module data_mux
  import mux_pkg::*;
#(
  parameter string ARCHITECTURE = ARCH_BEHAVIORAL,
  parameter int    SELECT_LINES = 4,
  parameter int    DATA_WIDTH   = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [SELECT_LINES-1:0]  select,
  input  logic [DATA_WIDTH*(2**SELECT_LINES)-1:0] data_in,
  input  logic                     data_valid_in,
  output logic [DATA_WIDTH-1:0]    data_out,
  output logic                     data_valid_out
);

  localparam int N  = 2**SELECT_LINES;
  localparam int DW = DATA_WIDTH;

  logic [SELECT_LINES-1:0] sel_s;
  logic [N*DW-1:0]         data_s;
  logic                    vld_s;
  logic [DW-1:0]           mux_y;

`ifdef MUX_INPUT_REG_EN
  logic [SELECT_LINES-1:0] sel_q;
  logic [N*DW-1:0]         data_q;
  logic                    vld_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q  <= '0;
      data_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      sel_q  <= select;
      data_q <= data_in;
      vld_q  <= data_valid_in;
    end
  end

  assign sel_s  = sel_q;
  assign data_s = data_q;
  assign vld_s  = vld_q;
`else
  assign sel_s  = select;
  assign data_s = data_in;
  assign vld_s  = data_valid_in;
`endif

  if (ARCHITECTURE == ARCH_STRUCTURAL) begin : g_struct
    // Level l halves the word count using select bit l.
    for (genvar l = 0; l < SELECT_LINES; l++) begin : g_lvl
      localparam int M = N >> (l + 1);
      logic [2*M*DW-1:0] x;
      logic [M*DW-1:0]   y;
      if (l == 0) begin : g_in
        assign x = data_s;
      end else begin : g_in
        assign x = g_lvl[l-1].y;
      end
      for (genvar k = 0; k < M; k++) begin : g_m
        mux2 #(.DATA_WIDTH(DW)) u_mux2 (
          .sel (sel_s[l]),
          .a   (x[(2*k)*DW +: DW]),
          .b   (x[(2*k+1)*DW +: DW]),
          .y   (y[k*DW +: DW])
        );
      end
    end
    assign mux_y = g_lvl[SELECT_LINES-1].y;
  end else begin : g_behav
    assign mux_y = data_s[sel_s*DW +: DW];
  end

  logic [DW-1:0] dout_d, dout_q;
  logic          vld_d,  vld_out_q;

  assign dout_d = mux_y;
  assign vld_d  = vld_s;

  always_ff @(posedge clk) begin
    if (rst) begin
      dout_q    <= '0;
      vld_out_q <= 1'b0;
    end else begin
      dout_q    <= dout_d;
      vld_out_q <= vld_d;
    end
  end

  assign data_out       = dout_q;
  assign data_valid_out = vld_out_q;

endmodule

// File: tb/tb_data_mux.sv
// Self-checking bench for data_mux, both architectures.
// Reference model: word pick by shift plus a delay line.
module tb_data_mux;
  import mux_pkg::*;

  localparam int LAT = LATENCY;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  sel = '0;
  logic [31:0] din = '0;
  logic [15:0] din_w = '0;
  logic        vld = 1'b0;

  logic [1:0]  ob, os;
  logic        vb, vs;
  logic [7:0]  owb, ows;
  logic        vwb, vws;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  data_mux #(
    .ARCHITECTURE("BEHAVIORAL"),
    .SELECT_LINES(4), .DATA_WIDTH(2)
  ) dut_b (
    .clk(clk), .rst(rst), .select(sel),
    .data_in(din), .data_valid_in(vld),
    .data_out(ob), .data_valid_out(vb)
  );

  data_mux #(
    .ARCHITECTURE("STRUCTURAL"),
    .SELECT_LINES(4), .DATA_WIDTH(2)
  ) dut_s (
    .clk(clk), .rst(rst), .select(sel),
    .data_in(din), .data_valid_in(vld),
    .data_out(os), .data_valid_out(vs)
  );

  data_mux #(
    .ARCHITECTURE("BEHAVIORAL"),
    .SELECT_LINES(1), .DATA_WIDTH(8)
  ) dut_wb (
    .clk(clk), .rst(rst), .select(sel[0]),
    .data_in(din_w), .data_valid_in(vld),
    .data_out(owb), .data_valid_out(vwb)
  );

  data_mux #(
    .ARCHITECTURE("STRUCTURAL"),
    .SELECT_LINES(1), .DATA_WIDTH(8)
  ) dut_ws (
    .clk(clk), .rst(rst), .select(sel[0]),
    .data_in(din_w), .data_valid_in(vld),
    .data_out(ows), .data_valid_out(vws)
  );

  task automatic check(
    input string       name,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  // Delay-line reference model.
  logic [1:0] pd [LAT];
  logic [7:0] pw [LAT];
  logic       pv [LAT];
  logic       armed = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++) begin
        pd[i] <= '0;
        pw[i] <= '0;
        pv[i] <= 1'b0;
      end
      armed <= 1'b1;
    end else begin
      for (int i = LAT - 1; i > 0; i--) begin
        pd[i] <= pd[i-1];
        pw[i] <= pw[i-1];
        pv[i] <= pv[i-1];
      end
      pd[0] <= 2'((din >> (int'(sel) * 2)) & 32'h3);
      pw[0] <= 8'((din_w >> (int'(sel[0]) * 8)) & 16'hFF);
      pv[0] <= vld;
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      check("beh_data", 32'(ob), 32'(pd[LAT-1]));
      check("str_data", 32'(os), 32'(pd[LAT-1]));
      check("beh_vld", 32'(vb), 32'(pv[LAT-1]));
      check("str_vld", 32'(vs), 32'(pv[LAT-1]));
      check("w_beh_data", 32'(owb), 32'(pw[LAT-1]));
      check("w_str_data", 32'(ows), 32'(pw[LAT-1]));
      check("w_beh_vld", 32'(vwb), 32'(pv[LAT-1]));
      check("w_str_vld", 32'(vws), 32'(pv[LAT-1]));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  logic [31:0] pat;
  logic [1:0]  e2;
  logic [7:0]  e8;

  initial begin
    pat = '0;
    for (int i = 0; i < 16; i++)
      pat[i*2 +: 2] = 2'(i);

    rst = 1'b1;
    repeat (3) tick();
    check("rst_data", 32'(ob), 32'h0);
    check("rst_vld", 32'(vs), 32'h0);
    rst = 1'b0;

    // Sweep with 0x155: words 0..4 = 01, rest 00.
    din   = 32'h0000_0155;
    din_w = 16'hA55A;
    vld   = 1'b1;
    for (int s = 0; s < 16; s++) begin
      sel = 4'(s);
      repeat (LAT) tick();
      e2 = (s <= 4) ? 2'b01 : 2'b00;
      e8 = s[0] ? 8'hA5 : 8'h5A;
      check("sweep_beh", 32'(ob), 32'(e2));
      check("sweep_str", 32'(os), 32'(e2));
      check("sweep_vld", 32'(vb), 32'h1);
      check("sweep_w", 32'(ows), 32'(e8));
    end

    // Reset with valid asserted, select 3.
    din = pat;
    sel = 4'd3;
    rst = 1'b1;
    tick();
    check("mid_rst_data", 32'(ob), 32'h0);
    check("mid_rst_vld", 32'(vb), 32'h0);
    tick();
    check("mid_rst_vld2", 32'(vs), 32'h0);
    rst = 1'b0;
    repeat (LAT) tick();
    check("post_rst_vld", 32'(vb), 32'h1);
    check("post_rst_beh", 32'(ob), 32'h3);
    check("post_rst_str", 32'(os), 32'h3);

    // Valid toggling 1,0,1.
    vld = 1'b1; sel = 4'd6; tick();
    vld = 1'b0; sel = 4'd9; tick();
    vld = 1'b1; sel = 4'd14; tick();
    repeat (LAT - 1) tick();
    check("tog_vld", 32'(vb), 32'h1);
    check("tog_data", 32'(os), 32'h2);

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 600; n++) begin
      rst   = ($urandom_range(0, 39) == 0);
      sel   = 4'($urandom);
      din   = $urandom_range(0, 1) ? pat : $urandom;
      din_w = 16'($urandom);
      vld   = 1'($urandom);
      tick();
    end
    rst = 1'b0;
    repeat (4) tick();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
